// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types and constants for the I2S/TDM slot controller
package i2s_pkg;

  localparam int MAX_SLOTS = 8;
  localparam int SLOT_W    = $clog2(MAX_SLOTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  // Right-justify mask for a word of (num_bits + 1) bits
  function automatic logic [31:0] width_mask(input logic [4:0] num_bits);
    return 32'hFFFF_FFFF >> (5'd31 - num_bits);
  endfunction

endpackage

// File: rtl/i2s_tdm_out_reg.sv
// rtl/i2s_tdm_out_reg.sv - one-deep valid/ready output register with sticky overrun
module i2s_tdm_out_reg
  import i2s_pkg::*;
(
  input  logic              sck,
  input  logic              rstn,
  input  logic              flush,
  input  logic              clr,
  input  logic              load,
  input  logic [31:0]       load_data,
  input  logic [SLOT_W-1:0] load_slot,
  input  logic              ready,
  output logic [31:0]       data,
  output logic [SLOT_W-1:0] slot,
  output logic              valid,
  output logic              overrun
);

  logic stalled;

  // Register is blocked only when holding a word the consumer is not taking this edge
  assign stalled = valid && !ready;

  // Output holding register; a load on a handshake edge replaces the departing word
  always_ff @(posedge sck or negedge rstn) begin
    if (!rstn) begin
      data    <= '0;
      slot    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (flush) begin
        valid <= 1'b0;
      end else if (load && !stalled) begin
        data  <= load_data;
        slot  <= load_slot;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end

      if (load && stalled && !flush) begin
        overrun <= 1'b1;
      end else if (clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2s_tdm_slot_ctrl.sv
// rtl/i2s_tdm_slot_ctrl.sv - DSP-mode TDM slot deserialiser; I2S_TDM_SYNC_CHECK_EN enables mid-frame ws checking
module i2s_tdm_slot_ctrl
  import i2s_pkg::*;
#(
  parameter int MAX_SLOTS = 8
) (
  input  logic                 sck_i,
  input  logic                 rstn_i,
  input  logic                 cfg_en_i,
  input  logic [4:0]           cfg_num_bits_i,
  input  logic [2:0]           cfg_num_words_i,
  input  logic [MAX_SLOTS-1:0] cfg_slot_mask_i,
  input  logic                 clr_i,
  input  logic                 ws_i,
  input  logic                 sd_i,
  output logic [31:0]          data_o,
  output logic [SLOT_W-1:0]    slot_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  output logic                 sync_err_o
);

  state_t            state, state_nxt;
  logic [4:0]        bit_cnt, bit_cnt_nxt;
  logic [SLOT_W-1:0] slot_cnt, slot_cnt_nxt;
  logic [31:0]       shift, shift_nxt, shifted;
  logic              last_bit, last_slot;
  logic              cap_nxt, cap_valid;
  logic [31:0]       cap_word;
  logic [SLOT_W-1:0] cap_slot;
`ifdef I2S_TDM_SYNC_CHECK_EN
  logic              sync_evt;
`endif

  assign shifted   = {shift[30:0], sd_i};
  assign last_bit  = (bit_cnt == cfg_num_bits_i);
  assign last_slot = (slot_cnt == cfg_num_words_i);

  // Frame tracking: next state, counters, shifter and capture decision
  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    slot_cnt_nxt = slot_cnt;
    shift_nxt    = shift;
    cap_nxt      = 1'b0;
`ifdef I2S_TDM_SYNC_CHECK_EN
    sync_evt     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        state_nxt = ST_SYNC;
      end
      ST_SYNC: begin
        if (ws_i) begin
          state_nxt    = ST_ACTIVE;
          bit_cnt_nxt  = '0;
          slot_cnt_nxt = '0;
          shift_nxt    = '0;
        end
      end
      ST_ACTIVE: begin
        shift_nxt = shifted;
        if (last_bit) begin
          bit_cnt_nxt = '0;
          cap_nxt     = cfg_slot_mask_i[slot_cnt];
          if (last_slot) begin
            slot_cnt_nxt = '0;
            if (!ws_i) state_nxt = ST_SYNC;
          end else begin
            slot_cnt_nxt = slot_cnt + 1'b1;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + 5'd1;
        end
`ifdef I2S_TDM_SYNC_CHECK_EN
        // A frame sync anywhere but the frame boundary realigns to slot 0
        if (ws_i && !(last_bit && last_slot)) begin
          sync_evt     = 1'b1;
          cap_nxt      = 1'b0;
          bit_cnt_nxt  = '0;
          slot_cnt_nxt = '0;
          shift_nxt    = '0;
        end
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    // Disable overrides everything and clears the datapath
    if (!cfg_en_i) begin
      state_nxt    = ST_IDLE;
      bit_cnt_nxt  = '0;
      slot_cnt_nxt = '0;
      shift_nxt    = '0;
      cap_nxt      = 1'b0;
    end
  end

  // State, counters and one-stage capture pipe (gives the one-sck output latency)
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      slot_cnt  <= '0;
      shift     <= '0;
      cap_valid <= 1'b0;
      cap_word  <= '0;
      cap_slot  <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      slot_cnt  <= slot_cnt_nxt;
      shift     <= shift_nxt;
      cap_valid <= cap_nxt;
      if (cap_nxt) begin
        cap_word <= shifted & width_mask(cfg_num_bits_i);
        cap_slot <= slot_cnt;
      end
    end
  end

`ifdef I2S_TDM_SYNC_CHECK_EN
  // Sticky sync error; a new error on a clear edge keeps the flag set
  always_ff @(posedge sck_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync_err_o <= 1'b0;
    end else if (sync_evt) begin
      sync_err_o <= 1'b1;
    end else if (clr_i) begin
      sync_err_o <= 1'b0;
    end
  end
`else
  assign sync_err_o = 1'b0;
`endif

  i2s_tdm_out_reg u_out_reg (
    .sck       (sck_i),
    .rstn      (rstn_i),
    .flush     (!cfg_en_i),
    .clr       (clr_i),
    .load      (cap_valid),
    .load_data (cap_word),
    .load_slot (cap_slot),
    .ready     (ready_i),
    .data      (data_o),
    .slot      (slot_o),
    .valid     (valid_o),
    .overrun   (overrun_o)
  );

endmodule
